// File: rtl/ps2_keymap_decoder.sv
// PS/2 scancode-set-2 decoder: prefix FSM with timeout, per-key levels, typematic-filtered
// strobes and a timed Ctrl+Alt+Backspace hard reset.
module ps2_keymap_decoder #(
  parameter int          NUM_JOY     = 2,
  parameter int          JOY_W       = 10,
  parameter logic [15:0] PFX_TIMEOUT = 16'd50000,
  parameter logic [23:0] HR_HOLD     = 24'd5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_byte,
  input  logic             ps2_valid,
  input  logic             ps2_error,
  output logic [JOY_W-1:0] key_joy1,
  output logic [JOY_W-1:0] key_joy2,
  output logic [2:0]       game_sel,
  output logic             game_sel_stb,
  output logic             key_start,
  output logic             start_stb,
  output logic             key_reset,
  output logic             key_hardreset,
  output logic             key_modovideo
);
  typedef enum logic [2:0] {IDLE, EXT, REL, EXT_REL, PAUSE} state_t;

  localparam int K_U_E = 0,  K_U_P = 1,  K_D_E = 2,  K_D_P = 3,  K_L = 4,  K_R = 5;
  localparam int K_B1 = 6,   K_B2 = 7,   K_B3 = 8;
  localparam int K_J2U = 9,  K_J2D = 10, K_J2L = 11, K_J2R = 12;
  localparam int K_J2B1 = 13, K_J2B2 = 14, K_J2B3 = 15;
  localparam int K_START = 16, K_F3 = 17, K_F12 = 18, K_SCRL = 19;
  localparam int K_CTRL = 20, K_ALT = 21, K_BKSP = 22, NK = 23;
  localparam logic [7:0] GAME_CODE [7] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};

  state_t        state_reg;
  logic [2:0]    skip_reg;
  logic [15:0]   pfx_reg;
  logic [NK-1:0] lvl_reg, lvl_next, hit;
  logic [6:0]    game_lvl_reg, game_lvl_next, game_hit, game_new;
  logic [23:0]   hr_reg, hr_next;
  logic [2:0]    game_sel_reg, game_sel_next;
  logic          game_stb_reg, start_stb_reg, video_reg;
  logic          accept, is_ext, is_brk, decode_en, bat;

  assign accept = ps2_valid && !ps2_error;
  assign is_ext = (state_reg == EXT) || (state_reg == EXT_REL);
  assign is_brk = (state_reg == REL) || (state_reg == EXT_REL);
  assign bat    = accept && (state_reg == IDLE) && (ps2_byte == 8'hAA || ps2_byte == 8'hFC);

  always_comb begin
    decode_en = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE:         decode_en = (ps2_byte != 8'hE0) && (ps2_byte != 8'hF0) && (ps2_byte != 8'hE1);
        EXT:          decode_en = (ps2_byte != 8'hF0);
        REL, EXT_REL: decode_en = 1'b1;
        default:      decode_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    hit = '0;
    case (ps2_byte)
      8'h75: hit[K_U_E]  = is_ext;
      8'h44: hit[K_U_P]  = !is_ext;
      8'h72: hit[K_D_E]  = is_ext;
      8'h42: hit[K_D_P]  = !is_ext;
      8'h6B: hit[K_L]    = is_ext;
      8'h74: hit[K_R]    = is_ext;
      8'h14: begin hit[K_B1] = is_ext; hit[K_CTRL] = !is_ext; end
      8'h11: begin hit[K_B2] = is_ext; hit[K_ALT]  = !is_ext; end
      8'h29: hit[K_B3]   = 1'b1;
      8'h15: hit[K_J2U]  = 1'b1;
      8'h1C: hit[K_J2D]  = 1'b1;
      8'h1B: hit[K_J2L]  = 1'b1;
      8'h23: hit[K_J2R]  = 1'b1;
      8'h1A: hit[K_J2B1] = 1'b1;
      8'h22: hit[K_J2B2] = 1'b1;
      8'h21: hit[K_J2B3] = 1'b1;
      8'h05: hit[K_START] = 1'b1;
      8'h04: hit[K_F3]   = 1'b1;
      8'h07: hit[K_F12]  = 1'b1;
      8'h7E: hit[K_SCRL] = 1'b1;
      8'h66: hit[K_BKSP] = 1'b1;
      default: ;
    endcase
    if (!decode_en) hit = '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_game
      assign game_hit[gi] = decode_en && (ps2_byte == GAME_CODE[gi]);
    end
  endgenerate

  // A make for a key already down is typematic repeat: it may not strobe or toggle.
  assign game_new = game_hit & ~game_lvl_reg & {7{!is_brk}};

  always_comb begin
    lvl_next      = lvl_reg;
    game_lvl_next = game_lvl_reg;
    for (int i = 0; i < NK; i++)
      if (hit[i]) lvl_next[i] = !is_brk;
    for (int i = 0; i < 7; i++)
      if (game_hit[i]) game_lvl_next[i] = !is_brk;
    if (bat) begin
      lvl_next      = '0;
      game_lvl_next = '0;
    end
  end

  always_comb begin
    game_sel_next = game_sel_reg;
    for (int i = 0; i < 7; i++)
      if (game_new[i]) game_sel_next = 3'(i);
  end

  always_comb begin
    hr_next = 24'd0;
    if (lvl_next[K_CTRL] && lvl_next[K_ALT] && lvl_next[K_BKSP])
      hr_next = (hr_reg == HR_HOLD) ? hr_reg : hr_reg + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      skip_reg      <= 3'd0;
      pfx_reg       <= 16'd0;
      lvl_reg       <= '0;
      game_lvl_reg  <= '0;
      hr_reg        <= 24'd0;
      game_sel_reg  <= 3'd0;
      game_stb_reg  <= 1'b0;
      start_stb_reg <= 1'b0;
      video_reg     <= 1'b0;
    end else begin
      lvl_reg       <= lvl_next;
      game_lvl_reg  <= game_lvl_next;
      hr_reg        <= hr_next;
      game_sel_reg  <= game_sel_next;
      game_stb_reg  <= |game_new;
      start_stb_reg <= hit[K_START] && !is_brk && !lvl_reg[K_START];
      if (hit[K_SCRL] && !is_brk && !lvl_reg[K_SCRL]) video_reg <= !video_reg;

      if (ps2_error) begin
        state_reg <= IDLE;
        pfx_reg   <= 16'd0;
      end else if (ps2_valid) begin
        pfx_reg <= 16'd0;
        case (state_reg)
          IDLE: begin
            if (ps2_byte == 8'hE0)      state_reg <= EXT;
            else if (ps2_byte == 8'hF0) state_reg <= REL;
            else if (ps2_byte == 8'hE1) begin
              state_reg <= PAUSE;
              skip_reg  <= 3'd7;
            end
          end
          EXT:     state_reg <= (ps2_byte == 8'hF0) ? EXT_REL : IDLE;
          PAUSE: begin
            if (skip_reg == 3'd1) state_reg <= IDLE;
            skip_reg <= skip_reg - 3'd1;
          end
          default: state_reg <= IDLE;
        endcase
      end else if (state_reg != IDLE) begin
        if (pfx_reg == PFX_TIMEOUT) begin
          state_reg <= IDLE;
          pfx_reg   <= 16'd0;
        end else begin
          pfx_reg <= pfx_reg + 16'd1;
        end
      end
    end
  end

  assign key_joy1[6:0] = {lvl_reg[K_B3], lvl_reg[K_B2], lvl_reg[K_B1],
                          lvl_reg[K_U_E] | lvl_reg[K_U_P], lvl_reg[K_D_E] | lvl_reg[K_D_P],
                          lvl_reg[K_L], lvl_reg[K_R]};
  generate
    if (NUM_JOY >= 2) begin : g_joy2
      assign key_joy2[6:0] = {lvl_reg[K_J2B3], lvl_reg[K_J2B2], lvl_reg[K_J2B1],
                              lvl_reg[K_J2U], lvl_reg[K_J2D], lvl_reg[K_J2L], lvl_reg[K_J2R]};
    end else begin : g_nojoy2
      assign key_joy2[6:0] = 7'd0;
    end
    for (gi = 7; gi < JOY_W; gi++) begin : g_pad
      assign key_joy1[gi] = 1'b0;
      assign key_joy2[gi] = 1'b0;
    end
  endgenerate

  assign game_sel      = game_sel_reg;
  assign game_sel_stb  = game_stb_reg;
  assign key_start     = lvl_reg[K_START];
  assign start_stb     = start_stb_reg;
  assign key_reset     = lvl_reg[K_F3] | lvl_reg[K_F12];
  assign key_hardreset = (hr_reg == HR_HOLD);
  assign key_modovideo = video_reg;
endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Bench for ps2_keymap_decoder: directed scenarios plus a random byte stream checked
// against a prefix/key-table reference model.
module tb_ps2_keymap_decoder;
  localparam int JOY_W = 10;
  localparam int PT    = 20;
  localparam int HR    = 40;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] ps2_byte = 8'h00;
  logic ps2_valid = 1'b0, ps2_error = 1'b0;
  logic [JOY_W-1:0] key_joy1, key_joy2;
  logic [2:0] game_sel;
  logic game_sel_stb, key_start, start_stb, key_reset, key_hardreset, key_modovideo;

  ps2_keymap_decoder #(.NUM_JOY(2), .JOY_W(JOY_W), .PFX_TIMEOUT(16'(PT)), .HR_HOLD(24'(HR))) dut (
    .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_valid(ps2_valid), .ps2_error(ps2_error),
    .key_joy1(key_joy1), .key_joy2(key_joy2), .game_sel(game_sel), .game_sel_stb(game_sel_stb),
    .key_start(key_start), .start_stb(start_stb), .key_reset(key_reset),
    .key_hardreset(key_hardreset), .key_modovideo(key_modovideo));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: logical key ids 0..22, game keys separately.
  bit held[23];
  bit gheld[7];
  int m_game = 0, m_hr = 0, skip = 0, idle_cnt = 0;
  bit m_vid = 0, e_start_stb = 0, e_game_stb = 0;
  logic [7:0] pend[$];

  function automatic int key_id(bit ext, logic [7:0] c);
    case (c)
      8'h75: key_id = ext ? 0 : -1;
      8'h44: key_id = ext ? -1 : 1;
      8'h72: key_id = ext ? 2 : -1;
      8'h42: key_id = ext ? -1 : 3;
      8'h6B: key_id = ext ? 4 : -1;
      8'h74: key_id = ext ? 5 : -1;
      8'h14: key_id = ext ? 6 : 20;
      8'h11: key_id = ext ? 7 : 21;
      8'h29: key_id = 8;   8'h15: key_id = 9;   8'h1C: key_id = 10;  8'h1B: key_id = 11;
      8'h23: key_id = 12;  8'h1A: key_id = 13;  8'h22: key_id = 14;  8'h21: key_id = 15;
      8'h05: key_id = 16;  8'h04: key_id = 17;  8'h07: key_id = 18;  8'h7E: key_id = 19;
      8'h66: key_id = 22;
      default: key_id = -1;
    endcase
  endfunction

  function automatic int game_idx(logic [7:0] c);
    case (c)
      8'h16: game_idx = 0; 8'h1E: game_idx = 1; 8'h26: game_idx = 2; 8'h25: game_idx = 3;
      8'h2E: game_idx = 4; 8'h36: game_idx = 5; 8'h3D: game_idx = 6;
      default: game_idx = -1;
    endcase
  endfunction

  function automatic logic [JOY_W-1:0] exp_joy1();
    logic [JOY_W-1:0] j = '0;
    j[0] = held[5]; j[1] = held[4]; j[2] = held[2] | held[3]; j[3] = held[0] | held[1];
    j[4] = held[6]; j[5] = held[7]; j[6] = held[8];
    return j;
  endfunction

  function automatic logic [JOY_W-1:0] exp_joy2();
    logic [JOY_W-1:0] j = '0;
    j[0] = held[12]; j[1] = held[11]; j[2] = held[10]; j[3] = held[9];
    j[4] = held[13]; j[5] = held[14]; j[6] = held[15];
    return j;
  endfunction

  function automatic void model_reset();
    foreach (held[i]) held[i] = 0;
    foreach (gheld[i]) gheld[i] = 0;
    m_game = 0; m_hr = 0; skip = 0; idle_cnt = 0; m_vid = 0;
    e_start_stb = 0; e_game_stb = 0;
    pend.delete();
  endfunction

  function automatic void model_step(bit v, logic [7:0] b, bit e);
    bit ext, brk;
    int id, g;
    e_start_stb = 0; e_game_stb = 0;
    if (e) begin
      pend.delete(); skip = 0; idle_cnt = 0;
    end else if (v) begin
      idle_cnt = 0;
      if (skip > 0) skip--;
      else if (pend.size() == 0 && b == 8'hE1) skip = 7;
      else if (pend.size() == 0 && b == 8'hE0) pend.push_back(b);
      else if (b == 8'hF0 && (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0)))
        pend.push_back(b);
      else begin
        ext = 0; brk = 0;
        foreach (pend[i]) begin
          if (pend[i] == 8'hE0) ext = 1;
          if (pend[i] == 8'hF0) brk = 1;
        end
        if (pend.size() == 0 && (b == 8'hAA || b == 8'hFC)) begin
          foreach (held[i]) held[i] = 0;
          foreach (gheld[i]) gheld[i] = 0;
        end
        pend.delete();
        id = key_id(ext, b);
        g  = game_idx(b);
        if (id >= 0) begin
          if (!brk && !held[id] && id == 16) e_start_stb = 1;
          if (!brk && !held[id] && id == 19) m_vid = !m_vid;
          held[id] = !brk;
        end
        if (g >= 0) begin
          if (!brk && !gheld[g]) begin m_game = g; e_game_stb = 1; end
          gheld[g] = !brk;
        end
      end
    end else if (pend.size() > 0 || skip > 0) begin
      idle_cnt++;
      if (idle_cnt > PT) begin pend.delete(); skip = 0; idle_cnt = 0; end
    end
    if (held[20] && held[21] && held[22]) m_hr = (m_hr < HR) ? m_hr + 1 : m_hr;
    else m_hr = 0;
  endfunction

  task automatic tick(input bit v, input logic [7:0] b, input bit e);
    ps2_valid = v; ps2_byte = b; ps2_error = e;
    model_step(v, b, e);
    @(posedge clk);
    @(negedge clk);
    ps2_valid = 1'b0; ps2_error = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    model_reset();
    if ({key_joy1, key_joy2} !== '0) begin
      $display("FAIL reset_joy got=%h exp=0", {key_joy1, key_joy2}); fails++; end
    tests++;
    if ({game_sel, game_sel_stb, start_stb, key_start} !== '0) begin
      $display("FAIL reset_game_start got=%h exp=0", {game_sel, game_sel_stb, start_stb, key_start}); fails++; end
    tests++;
    if ({key_reset, key_hardreset, key_modovideo} !== '0) begin
      $display("FAIL reset_sys got=%b exp=000", {key_reset, key_hardreset, key_modovideo}); fails++; end
    tests++;
  endtask

  task automatic test_joy_ext();
    send(8'hE0);
    if (key_joy1[3] !== 1'b0) begin $display("FAIL joy_u_early got=%b exp=0", key_joy1[3]); fails++; end
    tests++;
    send(8'h75);
    if (key_joy1 !== 10'h008) begin $display("FAIL joy_u_make got=%h exp=008", key_joy1); fails++; end
    tests++;
    idle(3);
    send(8'hE0); send(8'hF0);
    if (key_joy1 !== 10'h008) begin $display("FAIL joy_u_mid_break got=%h exp=008", key_joy1); fails++; end
    tests++;
    send(8'h75);
    if (key_joy1 !== 10'h000) begin $display("FAIL joy_u_break got=%h exp=000", key_joy1); fails++; end
    tests++;
  endtask

  task automatic test_start();
    int cnt = 0;
    repeat (3) begin
      send(8'h05);
      cnt += int'(start_stb);
      idle(1);
    end
    if (cnt != 1) begin $display("FAIL start_pulses got=%0d exp=1", cnt); fails++; end
    tests++;
    if (key_start !== 1'b1) begin $display("FAIL start_level got=%b exp=1", key_start); fails++; end
    tests++;
    send(8'hF0); send(8'h05);
    if ({key_start, start_stb} !== 2'b00) begin
      $display("FAIL start_break got=%b exp=00", {key_start, start_stb}); fails++; end
    tests++;
  endtask

  task automatic test_game();
    int cnt = 0;
    send(8'h2E); cnt += int'(game_sel_stb);
    if (game_sel !== 3'd4) begin $display("FAIL game_sel_4 got=%0d exp=4", game_sel); fails++; end
    tests++;
    send(8'h16); cnt += int'(game_sel_stb);
    if (game_sel !== 3'd0) begin $display("FAIL game_sel_0 got=%0d exp=0", game_sel); fails++; end
    tests++;
    send(8'h16); cnt += int'(game_sel_stb);
    if (cnt != 2) begin $display("FAIL game_pulses got=%0d exp=2", cnt); fails++; end
    tests++;
    send(8'hF0); send(8'h2E); send(8'hF0); send(8'h16);
    if ({game_sel, game_sel_stb} !== 4'b0000) begin
      $display("FAIL game_break got=%h exp=0", {game_sel, game_sel_stb}); fails++; end
    tests++;
  endtask

  task automatic test_video();
    logic [3:0] seen;
    send(8'h7E); seen[0] = key_modovideo;
    send(8'h7E); seen[1] = key_modovideo;
    send(8'hF0); send(8'h7E);
    send(8'h7E); seen[2] = key_modovideo;
    send(8'hF0); send(8'h7E);
    send(8'h7E); seen[3] = key_modovideo;
    send(8'hF0); send(8'h7E);
    if (seen !== 4'b1011) begin $display("FAIL video_toggle got=%b exp=1011", seen); fails++; end
    tests++;
  endtask

  task automatic test_timeout();
    send(8'hE0); idle(PT + 1); send(8'h74);
    if (key_joy1 !== 10'h000) begin $display("FAIL timeout_discard got=%h exp=000", key_joy1); fails++; end
    tests++;
    send(8'hE0); idle(PT); send(8'h74);
    if (key_joy1 !== 10'h001) begin $display("FAIL timeout_edge_kept got=%h exp=001", key_joy1); fails++; end
    tests++;
    send(8'hE0); send(8'hF0); send(8'h74);
    if (key_joy1 !== 10'h000) begin $display("FAIL timeout_release got=%h exp=000", key_joy1); fails++; end
    tests++;
  endtask

  task automatic test_error();
    send(8'h29);
    send(8'hE0); tick(1'b1, 8'h75, 1'b1); send(8'h75);
    if (key_joy1 !== 10'h040) begin $display("FAIL error_drop got=%h exp=040", key_joy1); fails++; end
    tests++;
    send(8'hF0); send(8'h29);
    if (key_joy1 !== 10'h000) begin $display("FAIL error_release got=%h exp=000", key_joy1); fails++; end
    tests++;
  endtask

  task automatic test_hardreset();
    send(8'h14); send(8'h11); send(8'h66);
    for (int k = 1; k <= HR + 1; k++) begin
      if (key_hardreset !== (k >= HR)) begin
        $display("FAIL hr_timing k=%0d got=%b exp=%b", k, key_hardreset, k >= HR); fails++; end
      tests++;
      idle(1);
    end
    send(8'hF0);
    if (key_hardreset !== 1'b1) begin $display("FAIL hr_hold_prefix got=%b exp=1", key_hardreset); fails++; end
    tests++;
    send(8'h66);
    if (key_hardreset !== 1'b0) begin $display("FAIL hr_release got=%b exp=0", key_hardreset); fails++; end
    tests++;
    send(8'h66);
    foreach (pend[i]) pend[i] = pend[i];
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(HR);
    if (key_hardreset !== 1'b1) begin $display("FAIL hr_pause_ctrl got=%b exp=1", key_hardreset); fails++; end
    tests++;
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h11); send(8'hF0); send(8'h66);
  endtask

  task automatic test_bat();
    int g = m_game;
    bit v = m_vid;
    send(8'hE0); send(8'h6B); send(8'h15);
    if ({key_joy1[1], key_joy2[3]} !== 2'b11) begin
      $display("FAIL bat_setup got=%b exp=11", {key_joy1[1], key_joy2[3]}); fails++; end
    tests++;
    send(8'hAA);
    if ({key_joy1, key_joy2} !== '0) begin
      $display("FAIL bat_clear got=%h exp=0", {key_joy1, key_joy2}); fails++; end
    tests++;
    if ({game_sel, key_modovideo} !== {3'(g), v}) begin
      $display("FAIL bat_keep got=%h exp=%h", {game_sel, key_modovideo}, {3'(g), v}); fails++; end
    tests++;
  endtask

  task automatic test_rst_mid();
    send(8'hE0);
    rst = 1'b1; idle(1); rst = 1'b0;
    model_reset();
    if ({key_joy1, key_joy2, game_sel, key_start, key_reset, key_hardreset, key_modovideo} !== '0) begin
      $display("FAIL rst_mid_outputs got=%h exp=0",
               {key_joy1, key_joy2, game_sel, key_start, key_reset, key_hardreset, key_modovideo}); fails++; end
    tests++;
    send(8'h74);
    if (key_joy1 !== 10'h000) begin $display("FAIL rst_mid_fsm got=%h exp=000", key_joy1); fails++; end
    tests++;
    send(8'h29);
    if (key_joy1 !== 10'h040) begin $display("FAIL rst_mid_b3 got=%h exp=040", key_joy1); fails++; end
    tests++;
  endtask

  task automatic test_random();
    logic [7:0] pool[$];
    logic [28:0] got, exp;
    logic [7:0] b;
    int n, r;
    bit e;
    pool = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'hFC, 8'h75, 8'h44, 8'h72, 8'h42,
             8'h6B, 8'h74, 8'h14, 8'h14, 8'h11, 8'h11, 8'h66, 8'h66, 8'h29, 8'h15, 8'h1C, 8'h1B,
             8'h23, 8'h1A, 8'h22, 8'h21, 8'h05, 8'h04, 8'h07, 8'h7E, 8'h16, 8'h1E, 8'h26, 8'h25,
             8'h2E, 8'h36, 8'h3D};
    for (int t = 0; t < 800; t++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, pool.size() - 1)];
      e = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 29);
      n = (r == 0) ? PT - 1 + $urandom_range(0, 3) : (r == 1) ? HR + 3 : (r < 6) ? $urandom_range(1, 3) : 0;
      for (int c = 0; c <= n; c++) begin
        if (c == 0) tick(1'b1, b, e);
        else idle(1);
        got = {key_joy1, key_joy2, game_sel, game_sel_stb, key_start, start_stb, key_reset,
               key_hardreset, key_modovideo};
        exp = {exp_joy1(), exp_joy2(), 3'(m_game), e_game_stb, held[16], e_start_stb,
               held[17] | held[18], m_hr == HR, m_vid};
        if (got !== exp) begin
          $display("FAIL random t=%0d c=%0d byte=%h got=%h exp=%h", t, c, b, got, exp); fails++; end
        tests++;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_joy_ext();
    test_start();
    test_game();
    test_video();
    test_timeout();
    test_error();
    test_hardreset();
    test_bat();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
